// File: rtl/accum_pkg.sv
// Shared types for the slice accumulator: opcodes, FSM states and the
// slice-counter width helper.
package accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  // Counter must hold 0..nslice-1; at least one bit even when nslice == 1.
  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational WIDTH-bit adder with carry in; also reports the carry into
// the MSB so the caller can form signed overflow as c_msb ^ cout.
module slice_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [WIDTH:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    c_msb = a[WIDTH-1] ^ b[WIDTH-1] ^ full[WIDTH-1];
  end

endmodule

// File: rtl/slice_accumulator.sv
// Multi-cycle accumulator: ADD/SUB run through a bit-sliced adder one
// SLICE_WIDTH chunk per cycle; LOAD/CLEAR complete in a single cycle.
module slice_accumulator
  import accum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SLICE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic                  sign_o,
  output logic                  carry_o,
  output logic                  ovf_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned NSLICE = DATA_WIDTH / SLICE_WIDTH;
  localparam int unsigned CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (DATA_WIDTH < 2 || SLICE_WIDTH == 0 || (DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_param_check
    $error("slice_accumulator: DATA_WIDTH must be >= 2 and a multiple of SLICE_WIDTH");
  end

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] work_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic                  cy_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  carry_q;
  logic                  ovf_q;
  logic                  busy_q;
  logic                  done_q;

  logic [SLICE_WIDTH-1:0] s_sum;
  logic                   s_cout;
  logic                   s_cmsb;
  logic [DATA_WIDTH-1:0]  work_next;
  logic [DATA_WIDTH-1:0]  opnd_next;

  slice_adder #(
    .WIDTH (SLICE_WIDTH)
  ) u_adder (
    .a     (work_q[SLICE_WIDTH-1:0]),
    .b     (opnd_q[SLICE_WIDTH-1:0]),
    .cin   (cy_q),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Sums enter at the top of the work register, so after NSLICE shifts the
  // register holds the complete result in its natural bit order.
  if (NSLICE == 1) begin : g_single
    assign work_next = s_sum;
    assign opnd_next = '0;
  end else begin : g_multi
    assign work_next = {s_sum, work_q[DATA_WIDTH-1:SLICE_WIDTH]};
    assign opnd_next = {{SLICE_WIDTH{1'b0}}, opnd_q[DATA_WIDTH-1:SLICE_WIDTH]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      cy_q    <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            case (op_e'(op_i))
              OP_ADD, OP_SUB: begin
                opnd_q  <= (op_e'(op_i) == OP_SUB) ? ~data_i : data_i;
                cy_q    <= (op_e'(op_i) == OP_SUB);
                work_q  <= acc_q;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ST_CALC;
              end
              OP_LOAD: begin
                acc_q   <= data_i;
                carry_q <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
              OP_CLEAR: begin
                acc_q   <= '0;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_CALC: begin
          work_q <= work_next;
          opnd_q <= opnd_next;
          cy_q   <= s_cout;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            // Last slice carries the operand MSBs: carry-in vs carry-out of
            // the MSB gives the two's-complement overflow.
            acc_q   <= work_next;
            carry_q <= s_cout;
            ovf_q   <= ovf_q | (s_cmsb ^ s_cout);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acc_o   = acc_q;
  assign sign_o  = acc_q[DATA_WIDTH-1];
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_slice_accumulator.sv
// Scoreboard bench for slice_accumulator: 16/4 instance for the main cases,
// 8/8 instance for the single-slice configuration.
module tb_slice_accumulator;
  import accum_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic        s16;
  logic [1:0]  op16;
  logic [15:0] d16;
  logic [15:0] acc16;
  logic        sign16, carry16, ovf16, busy16, done16;

  logic        s8;
  logic [1:0]  op8;
  logic [7:0]  d8;
  logic [7:0]  acc8;
  logic        sign8, carry8, ovf8, busy8, done8;

  slice_accumulator #(.DATA_WIDTH(16), .SLICE_WIDTH(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start_i(s16), .op_i(op16), .data_i(d16),
    .acc_o(acc16), .sign_o(sign16), .carry_o(carry16), .ovf_o(ovf16),
    .busy_o(busy16), .done_o(done16)
  );

  slice_accumulator #(.DATA_WIDTH(8), .SLICE_WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start_i(s8), .op_i(op8), .data_i(d8),
    .acc_o(acc8), .sign_o(sign8), .carry_o(carry8), .ovf_o(ovf8),
    .busy_o(busy8), .done_o(done8)
  );

  typedef struct {
    logic [15:0] acc;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      if (q16.size() == 0) chk("dut16_spurious_done", done16, 0);
      else begin
        e = q16.pop_front();
        chk("dut16_acc", acc16, e.acc);
        chk("dut16_carry", carry16, e.carry);
        chk("dut16_ovf", ovf16, e.ovf);
        chk("dut16_sign", sign16, e.acc[15]);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) chk("dut8_spurious_done", done8, 0);
      else begin
        e = q8.pop_front();
        chk("dut8_acc", {8'h00, acc8}, e.acc);
        chk("dut8_carry", carry8, e.carry);
        chk("dut8_ovf", ovf8, e.ovf);
        chk("dut8_sign", sign8, e.acc[7]);
      end
    end
  end

  // Issue one operation, push its expected result, then time busy/done.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [15:0] data,
                        input logic [15:0] eacc, input logic ec, input logic eo,
                        input int exp_lat, input int exp_busy, input bit inject,
                        input string name);
    int lat;
    int nbusy;
    bit seen;
    logic [15:0] acc_before;
    @(posedge clk); #1;
    acc_before = sel ? {8'h00, acc8} : acc16;
    if (sel) begin
      s8 = 1'b1; op8 = op; d8 = data[7:0];
      q8.push_back('{eacc, ec, eo});
    end else begin
      s16 = 1'b1; op16 = op; d16 = data;
      q16.push_back('{eacc, ec, eo});
    end
    @(posedge clk); #1;
    s8 = 1'b0; s16 = 1'b0;
    lat = 0; nbusy = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? busy8 : busy16) begin
        nbusy++;
        chk({name, "_acc_stable"}, sel ? {8'h00, acc8} : acc16, acc_before);
      end
      if (inject && lat == 2) begin s16 = 1'b1; op16 = OP_LOAD; d16 = 16'hAAAA; end
      if (inject && lat == 3) s16 = 1'b0;
      if (sel ? done8 : done16) seen = 1'b1;
    end
    chk({name, "_done_seen"}, seen, 1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_busy_cycles"}, nbusy, exp_busy);
    if (inject) begin
      s16 = 1'b1; op16 = OP_LOAD; d16 = 16'hAAAA;
      @(posedge clk); #1;
      s16 = 1'b0;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    bit seen;
    reset_n = 1'b1;
    s16 = 1'b0; op16 = '0; d16 = '0;
    s8 = 1'b0; op8 = '0; d8 = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_acc16", acc16, 0);
    chk("reset_carry16", carry16, 0);
    chk("reset_ovf16", ovf16, 0);
    chk("reset_busy16", busy16, 0);
    chk("reset_done16", done16, 0);
    chk("reset_sign16", sign16, 0);
    chk("reset_acc8", acc8, 0);
    @(negedge clk) reset_n = 1'b1;

    run_op(0, OP_ADD,   16'h1234, 16'h1234, 0, 0, 5, 4, 0, "add_basic");
    run_op(0, OP_LOAD,  16'h0001, 16'h0001, 0, 0, 1, 0, 0, "load_1");
    run_op(0, OP_ADD,   16'hFFFF, 16'h0000, 1, 0, 5, 4, 0, "add_wrap");
    run_op(0, OP_LOAD,  16'h7FFF, 16'h7FFF, 0, 0, 1, 0, 0, "load_7fff");
    run_op(0, OP_ADD,   16'h0001, 16'h8000, 0, 1, 5, 4, 0, "add_ovf");
    run_op(0, OP_ADD,   16'h0000, 16'h8000, 0, 1, 5, 4, 0, "add_sticky");
    run_op(0, OP_CLEAR, 16'h5555, 16'h0000, 0, 0, 1, 0, 0, "clear");
    run_op(0, OP_LOAD,  16'h0005, 16'h0005, 0, 0, 1, 0, 0, "load_5");
    run_op(0, OP_SUB,   16'h0007, 16'hFFFE, 0, 0, 5, 4, 0, "sub_borrow");
    run_op(0, OP_SUB,   16'h0001, 16'hFFFD, 1, 0, 5, 4, 0, "sub_noborrow");
    run_op(0, OP_LOAD,  16'h0010, 16'h0010, 0, 0, 1, 0, 0, "load_10");
    run_op(0, OP_ADD,   16'h0101, 16'h0111, 0, 0, 5, 4, 1, "add_ignore");
    repeat (4) @(negedge clk);
    chk("ignored_start_acc", acc16, 16'h0111);

    run_op(0, OP_LOAD, 16'h00F0, 16'h00F0, 0, 0, 1, 0, 0, "load_f0");
    @(posedge clk); #1;
    s16 = 1'b1; op16 = OP_ADD; d16 = 16'h0F00;
    @(posedge clk); #1;
    s16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", busy16, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_acc", acc16, 0);
    chk("midrst_carry", carry16, 0);
    chk("midrst_ovf", ovf16, 0);
    chk("midrst_busy", busy16, 0);
    chk("midrst_done", done16, 0);
    chk("midrst_sign", sign16, 0);
    @(negedge clk);
    reset_n = 1'b1;
    s16 = 1'b1; op16 = OP_ADD; d16 = 16'h0003;
    q16.push_back('{16'h0003, 1'b0, 1'b0});
    @(posedge clk); #1;
    s16 = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy16, 1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done16) seen = 1'b1;
    end
    chk("restart_done_seen", seen, 1);

    run_op(1, OP_LOAD, 16'h0080, 16'h0080, 0, 0, 1, 0, 0, "p8_load");
    run_op(1, OP_ADD,  16'h0080, 16'h0000, 1, 1, 2, 1, 0, "p8_add");

    repeat (3) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_accumulator.md
# slice_accumulator

Parametrised, multi-cycle accumulator datapath: the successor to the single-cycle 17-bit add-and-load accumulator on the lab top level. Adds generic width, an add/sub/load/clear opcode, and a bit-sliced adder that consumes one SLICE_WIDTH-bit chunk per cycle. It reports flags and a busy/done handshake, and sits between the synchronised switch register plus run-edge detector and the hex display drivers.

## Interface
- DATA_WIDTH, 16, operand and accumulator width; must be ≥ 2.
- SLICE_WIDTH, 4, bits added per cycle; must divide DATA_WIDTH.
- Derived NSLICE = DATA_WIDTH/SLICE_WIDTH, the CALC cycle count.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request pulse, already synchronised and edge-detected upstream.
- op_i  in  2  operation, sampled with start_i: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
- data_i  in  DATA_WIDTH  operand, sampled with start_i.
- acc_o  out  DATA_WIDTH  accumulator value.
- sign_o  out  1  acc_o[DATA_WIDTH-1].
- carry_o  out  1  carry out of the last ADD/SUB; for SUB, 1 means no borrow.
- ovf_o  out  1  sticky signed-overflow flag.
- busy_o  out  1  high while in CALC.
- done_o  out  1  one-cycle pulse when a new result is visible.

## Operation
- State machine with states IDLE, CALC and DONE. Reset state is IDLE. At reset, every output and internal register is 0.
- **IDLE:**
  - start_i=1 with ADD or SUB: capture data_i into the operand shift register and snapshot acc into the work register. For SUB the operand is ~data_i and the carry register starts at 1; for ADD it starts at 0. Set slice counter = 0 and go to CALC.
  - start_i=1 with LOAD: acc ← data_i, carry_o ← 0, ovf_o unchanged. Go to DONE.
  - start_i=1 with CLEAR: acc ← 0, carry_o ← 0, ovf_o ← 0. Go to DONE.
- **CALC:**
  - Each cycle, add the low SLICE_WIDTH bits of the work register, the operand register and the carry register. Shift the sum into the top of the work register, shift the operand right by SLICE_WIDTH, and register the carry. Increment the counter.
  - On the cycle where counter = NSLICE-1, write the completed sum to acc. Set carry_o to the final carry. Set ovf_o to ovf_o OR the signed overflow, where overflow = (a_msb == b'_msb) && (sum_msb != a_msb) and b' is the possibly inverted operand. Go to DONE.
- **DONE:** lasts exactly one cycle with done_o=1, then returns to IDLE.
- start_i is ignored in CALC and DONE: no queueing and no effect.
- acc_o stays stable during CALC. It changes only on the writing edge.
- All arithmetic is modulo 2^DATA_WIDTH. The carry and overflow rules are as above.
- When reset_n is asserted mid-operation, the block immediately returns to IDLE with all outputs 0. The operation is abandoned and no done_o is issued.

## Timing
- Let edge E0 be the edge that samples start_i=1.
- ADD/SUB:
  - busy_o is high in the cycles after edges E0 … E(NSLICE-1), i.e. NSLICE cycles.
  - Edge E(NSLICE) writes acc. done_o=1 and the new acc_o, carry_o and ovf_o are visible in the following cycle.
  - Latency from start to done is NSLICE+1 cycles. The next start is accepted at E(NSLICE+2), giving a throughput of one operation per NSLICE+2 cycles.
- LOAD/CLEAR: E0 writes acc and done_o=1 in the following cycle, i.e. latency 1. The next start is accepted at E2.
- All outputs are registered; none is combinational from inputs.

## Structure
- Package accum_pkg holds:
  - the op_e enum (ADD, SUB, LOAD, CLEAR);
  - the state_e enum (IDLE, CALC, DONE);
  - the localparam helper for the slice-counter width, $clog2(NSLICE) clamped to ≥ 1.
- Sub-module slice_adder: combinational SLICE_WIDTH-bit adder with cin, producing the sum, cout and the carry into the MSB (for overflow). It is instantiated once.

## Test plan
All scenarios use DATA_WIDTH=16 and SLICE_WIDTH=4 (NSLICE=4) unless noted.
- **Basic ADD:** reset, then ADD 0x1234.
  - busy_o is high 4 cycles.
  - done_o pulses 5 cycles after E0.
  - acc_o=0x1234, carry_o=0, ovf_o=0.
- **Wrap:** LOAD 0x0001, then ADD 0xFFFF.
  - acc_o=0x0000, carry_o=1, ovf_o=0, sign_o=0.
- **Sticky overflow:** LOAD 0x7FFF, then ADD 0x0001.
  - acc_o=0x8000, ovf_o=1, sign_o=1.
  - A following ADD 0x0000 keeps ovf_o=1.
  - CLEAR then gives acc_o=0 and ovf_o=0 one cycle after its start.
- **SUB with borrow:** LOAD 0x0005, then SUB 0x0007.
  - acc_o=0xFFFE, carry_o=0.
  - A following SUB 0x0001 gives 0xFFFD with carry_o=1.
- **Ignored start and mid-operation reset:**
  - start_i pulses with LOAD 0xAAAA during CALC and in the DONE cycle are ignored; the result equals the single ADD.
  - reset_n low at the second CALC cycle makes all outputs 0 immediately. No done_o appears and the block accepts a new start at the first edge after release.
- **Parametric:** DATA_WIDTH=8, SLICE_WIDTH=8 (NSLICE=1).
  - ADD 0x80 to 0x80 gives acc_o=0x00, carry_o=1, ovf_o=1.
  - busy_o is high 1 cycle and done_o pulses 2 cycles after E0.
